// File: rtl/lsu_pkg.sv
// Shared encodings and defaults for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0040_0000;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Big-endian lane handling: extracts/extends a load lane and merges a
// sub-word store lane into a memory word. Purely combinational.
module lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  // byte_lane[0] is the most significant byte (offset 0).
  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam int         HI   = 31 - 8 * gi;
      logic       hit;
      logic [7:0] src;

      assign byte_lane[gi] = word[HI -: 8];

      // Decide whether this lane takes store data, and which store byte.
      always_comb begin
        hit = 1'b1;
        src = wdata[HI -: 8];
        case (size)
          SZ_BYTE: begin
            hit = (offset == LANE);
            src = wdata[7:0];
          end
          SZ_HALF: begin
            hit = (offset[1] == LANE[1]);
            src = LANE[0] ? wdata[7:0] : wdata[15:8];
          end
          default: ;
        endcase
      end

      assign merged[HI -: 8] = hit ? src : byte_lane[gi];
    end
  endgenerate

  assign byte_val = byte_lane[offset];
  assign half_val = offset[1] ? word[15:0] : word[31:16];

  // Select the addressed lane and extend it to 32 bits.
  always_comb begin
    ext_data = word;
    case (size)
      SZ_BYTE: ext_data = {{24{is_signed & byte_val[7]}}, byte_val};
      SZ_HALF: ext_data = {{16{is_signed & half_val[15]}}, half_val};
      default: ext_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store bus initiator: converts byte/half/word requests into
// word-aligned memory cycles, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_align,
  output logic        err_range,
  output logic [31:0] dir,
  output logic [31:0] data_input,
  output logic        mem_rd,
  output logic        mem_wd,
  input  logic [31:0] data_output
);

  // 33-bit limit so a base near the top of the address space cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  lsu_state_e  state_reg, state_next;
  logic [1:0]  off_reg, off_next;
  logic [1:0]  size_reg, size_next;
  logic        signed_reg, signed_next;
  logic        we_reg, we_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] buf_reg, buf_next;

  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_align_reg, err_align_next;
  logic        err_range_reg, err_range_next;
  logic [31:0] dir_reg, dir_next;
  logic [31:0] data_input_reg, data_input_next;
  logic        mem_rd_reg, mem_rd_next;
  logic        mem_wd_reg, mem_wd_next;

  logic [1:0]  req_size_eff;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  // Checks run on the live request so an error reaches DONE one cycle after accept.
  always_comb begin
    req_size_eff     = norm_size(req_size);
    req_misaligned   = ((req_size_eff == SZ_HALF) && req_addr[0]) ||
                       ((req_size_eff == SZ_WORD) && (req_addr[1:0] != 2'b00));
    req_out_of_range = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= LIMIT);
  end

  // Lanes are taken straight from the memory read data during RD, which is
  // the same word being captured into buf_reg on that edge.
  lane_merge u_lane_merge (
    .word      (data_output),
    .offset    (off_reg),
    .size      (size_reg),
    .is_signed (signed_reg),
    .wdata     (wdata_reg),
    .ext_data  (lane_rdata),
    .merged    (lane_merged)
  );

  // Next-state and next-output logic; every output is a flop fed from here.
  always_comb begin
    state_next      = state_reg;
    off_next        = off_reg;
    size_next       = size_reg;
    signed_next     = signed_reg;
    we_next         = we_reg;
    wdata_next      = wdata_reg;
    buf_next        = buf_reg;
    rdata_next      = rdata_reg;
    err_align_next  = err_align_reg;
    err_range_next  = err_range_reg;
    dir_next        = dir_reg;
    data_input_next = data_input_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          off_next       = req_addr[1:0];
          size_next      = req_size_eff;
          signed_next    = req_signed;
          we_next        = req_we;
          wdata_next     = req_wdata;
          dir_next       = {req_addr[31:2], 2'b00};
          err_align_next = req_misaligned;
          err_range_next = req_out_of_range;
          rdata_next     = 32'h0;
          if (req_misaligned || req_out_of_range) begin
            state_next = ST_DONE;
          end else if (!req_we || (req_size_eff != SZ_WORD)) begin
            state_next = ST_RD;
          end else begin
            state_next      = ST_WR;
            data_input_next = req_wdata;
          end
        end
      end
      ST_RD: begin
        buf_next = data_output;
        if (we_reg) begin
          state_next      = ST_WR;
          data_input_next = lane_merged;
        end else begin
          state_next = ST_DONE;
          rdata_next = lane_rdata;
        end
      end
      ST_WR: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next     = ST_IDLE;
        rdata_next     = 32'h0;
        err_align_next = 1'b0;
        err_range_next = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next   = (state_next != ST_IDLE);
    done_next   = (state_next == ST_DONE);
    mem_rd_next = (state_next == ST_RD);
    mem_wd_next = (state_next == ST_WR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      off_reg        <= 2'b00;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      we_reg         <= 1'b0;
      wdata_reg      <= 32'h0;
      buf_reg        <= 32'h0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      rdata_reg      <= 32'h0;
      err_align_reg  <= 1'b0;
      err_range_reg  <= 1'b0;
      dir_reg        <= 32'h0;
      data_input_reg <= 32'h0;
      mem_rd_reg     <= 1'b0;
      mem_wd_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      off_reg        <= off_next;
      size_reg       <= size_next;
      signed_reg     <= signed_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      buf_reg        <= buf_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      rdata_reg      <= rdata_next;
      err_align_reg  <= err_align_next;
      err_range_reg  <= err_range_next;
      dir_reg        <= dir_next;
      data_input_reg <= data_input_next;
      mem_rd_reg     <= mem_rd_next;
      mem_wd_reg     <= mem_wd_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign rdata      = rdata_reg;
  assign err_align  = err_align_reg;
  assign err_range  = err_range_reg;
  assign dir        = dir_reg;
  assign data_input = data_input_reg;
  assign mem_rd     = mem_rd_reg;
  assign mem_wd     = mem_wd_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a word-array reference model.
module tb_load_store_unit;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, err_align, err_range, mem_rd, mem_wd;
  logic [31:0] rdata, dir, data_input, data_output;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Memory attached to the DUT, plus a bench-side write port for preloading.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        tb_wr_en = 1'b0;
  logic [5:0]  tb_wr_idx = 6'd0;
  logic [31:0] tb_wr_val = 32'h0;
  logic        in_rng;

  assign in_rng      = (dir >= BASE) && (dir < BASE + 32'(4 * DEPTH));
  assign data_output = in_rng ? mem[dir[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_wd && in_rng) mem[dir[7:2]] <= data_input;
    else if (tb_wr_en)    mem[tb_wr_idx] <= tb_wr_val;
  end

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .err_align   (err_align),
    .err_range   (err_range),
    .dir         (dir),
    .data_input  (data_input),
    .mem_rd      (mem_rd),
    .mem_wd      (mem_wd),
    .data_output (data_output)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference lane extraction: shift the addressed big-endian lane down.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz,
                                           input int off, input logic sgn);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (3 - off))) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Reference store: mask out the target lane and insert the new bits.
  function automatic logic [31:0] ref_store(input logic [31:0] w, input int sz,
                                            input int off, input logic [31:0] wd);
    int sh;
    if (sz == 0) begin
      sh = 8 * (3 - off);
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (sz == 1) begin
      sh = (off >= 2) ? 0 : 16;
      return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic set_word(input int idx, input logic [31:0] val);
    tb_wr_en  = 1'b1;
    tb_wr_idx = 6'(idx);
    tb_wr_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    tb_wr_en = 1'b0;
  endtask

  // One full request: predicts everything, runs it, and checks it.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata);
    int sz, off, idx, exp_lat, exp_nrd, exp_nwd, got_lat, nrd, nwd;
    logic mis, oor, ga, gr;
    logic [31:0] exp_rdata, exp_new;
    sz  = (size == 2'b11) ? 2 : int'(size);
    off = int'(addr[1:0]);
    idx = int'(addr[7:2]);
    mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
    oor = (addr < BASE) || (addr >= BASE + 32'(4 * DEPTH));
    exp_rdata = 32'h0;
    exp_new   = 32'h0;
    if (mis || oor) begin
      exp_lat = 1; exp_nrd = 0; exp_nwd = 0;
    end else if (!we) begin
      exp_lat = 2; exp_nrd = 1; exp_nwd = 0;
      exp_rdata = ref_load(ref_mem[idx], sz, off, sgn);
    end else begin
      exp_lat = (sz == 2) ? 2 : 3;
      exp_nrd = (sz == 2) ? 0 : 1;
      exp_nwd = 1;
      exp_new = ref_store(ref_mem[idx], sz, off, wdata);
    end

    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    got_lat = 0; nrd = 0; nwd = 0; ga = 1'b0; gr = 1'b0; got_rdata = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_rd) nrd++;
      if (mem_wd) begin
        nwd++;
        check("wr_dir", dir, {addr[31:2], 2'b00});
        check("wr_data", data_input, exp_new);
      end
      if (done) begin
        got_lat = k; got_rdata = rdata; ga = err_align; gr = err_range;
        break;
      end
      @(negedge clk);
    end
    check("latency", 32'(got_lat), 32'(exp_lat));
    check("err_align", 32'(ga), 32'(mis));
    check("err_range", 32'(gr), 32'(oor));
    check("rdata", got_rdata, exp_rdata);
    check("mem_rd_cycles", 32'(nrd), 32'(exp_nrd));
    check("mem_wd_cycles", 32'(nwd), 32'(exp_nwd));
    @(negedge clk);
    check("idle_after", 32'(busy), 32'h0);
    if (!(mis || oor)) begin
      if (we) ref_mem[idx] = exp_new;
      check("mem_word", mem[idx], ref_mem[idx]);
    end
    n_txn++;
    $display("txn %0d we=%0d sz=%0d sgn=%0d addr=%h wdata=%h rdata=%h lat=%0d ea=%0d er=%0d",
             n_txn, we, size, sgn, addr, wdata, got_rdata, got_lat, ga, gr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, a;
    int n_done, d1, d2;
    logic [31:0] r1, r2;

    // Reset asserted together with a request: reset wins.
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = BASE; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_mem_wd", 32'(mem_wd), 32'h0);
    check("rst_dir", dir, 32'h0);
    check("rst_data_input", data_input, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    req_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) set_word(i, $urandom);
    set_word(1, 32'h14AA_0004);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_req(1'b0, 2'b10, 1'b0, 32'h0040_0004, 32'h0, r);
    check("tp_word_load", r, 32'h14AA_0004);
    do_req(1'b0, 2'b00, 1'b1, 32'h0040_0005, 32'h0, r);
    check("tp_byte_signed", r, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b00, 1'b0, 32'h0040_0005, 32'h0, r);
    check("tp_byte_unsigned", r, 32'h0000_00AA);
    do_req(1'b0, 2'b01, 1'b1, 32'h0040_0006, 32'h0, r);
    check("tp_half_signed", r, 32'h0000_0004);
    do_req(1'b1, 2'b01, 1'b0, 32'h0040_0006, 32'h1234_BEEF, r);
    do_req(1'b0, 2'b10, 1'b0, 32'h0040_0004, 32'h0, r);
    check("tp_half_readback", r, 32'h14AA_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h0040_0002, 32'h0, r);
    do_req(1'b0, 2'b00, 1'b0, 32'h0040_0003, 32'h0, r);
    do_req(1'b0, 2'b10, 1'b0, 32'h003F_FFFC, 32'h0, r);
    do_req(1'b1, 2'b10, 1'b0, 32'h0040_0100, 32'hDEAD_BEEF, r);
    do_req(1'b0, 2'b10, 1'b0, 32'h0040_00FC, 32'h0, r);
    do_req(1'b1, 2'b00, 1'b0, 32'h0040_00FF, 32'h0000_005A, r);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, r);
    do_req(1'b1, 2'b11, 1'b0, 32'h0040_0010, 32'hCAFE_F00D, r);
    do_req(1'b0, 2'b11, 1'b0, 32'h0040_0012, 32'h0, r);

    // Reset during WR of a byte store: no done, completed write kept.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = BASE + 32'h31; req_wdata = 32'h0000_00C3;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_rst_rd", 32'(mem_rd), 32'h1);
    @(negedge clk);
    check("mid_rst_wr", 32'(mem_wd), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_mem_wd", 32'(mem_wd), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_rst_no_done", 32'(n_done), 32'h0);
    ref_mem[12] = ref_store(ref_mem[12], 0, 1, 32'h0000_00C3);
    check("mid_rst_mem", mem[12], ref_mem[12]);

    // req_valid held through a busy load: new fields only taken after DONE.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = BASE + 32'h10;
    n_done = 0; d1 = 0; d2 = 0; r1 = 32'h0; r2 = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_addr = BASE + 32'h20;
      if (done) begin
        n_done++;
        if (n_done == 1) begin d1 = k; r1 = rdata; end
        else begin d2 = k; r2 = rdata; end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("held_done_count", 32'(n_done), 32'h2);
    check("held_first_cycle", 32'(d1), 32'h2);
    check("held_first_rdata", r1, ref_mem[4]);
    check("held_second_cycle", 32'(d2), 32'h5);
    check("held_second_rdata", r2, ref_mem[8]);
    check("held_idle", 32'(busy), 32'h0);

    // Random traffic, mostly in range with some boundary and wild addresses.
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE - 32'h4 + 32'($urandom_range(0, 3));
        2:       a = BASE + 32'd252 + 32'($urandom_range(0, 7));
        default: a = BASE + 32'($urandom_range(0, 255));
      endcase
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
